prog_counter: RTL and testbench
===============================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, count/limit width in bits; PRESCALE, default 1, enabled cycles per count step (>=1); WRAP, default 0, 0=saturate at limits, 1=wrap around.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 count_en  input  1  prescaler advances only while high.
REQ-005 up_dn  input  1  step direction: 1=up, 0=down; sampled on each step.
REQ-006 load  input  1  synchronous load request.
REQ-007 load_val  input  WIDTH  value written by load.
REQ-008 max  input  WIDTH  upper count limit, treated as unsigned; may change at any time.
REQ-009 count  output  WIDTH  registered current count.
REQ-010 at_max  output  1  combinational, high when count == max.
REQ-011 at_zero  output  1  combinational, high when count == 0.
REQ-012 tc_pulse  output  1  registered one-cycle terminal-count pulse.
REQ-013 wrap_pulse  output  1  registered one-cycle wrap-around pulse; always 0 when WRAP=0.

Function
REQ-014 Prescaler: internal counter psc, range 0..PRESCALE-1; holds when count_en=0.
REQ-015 Prescaler: when count_en=1 and psc < PRESCALE-1, psc SHALL increment; when count_en=1 and psc == PRESCALE-1, psc SHALL return to 0 and a step SHALL occur in that cycle.
REQ-016 Prescaler: PRESCALE=1 SHALL step on every cycle with count_en=1.
REQ-017 Priority SHALL be RESET > load > step.
REQ-018 Load: count SHALL become min(load_val, max) on the next edge.
REQ-019 Load: psc SHALL be cleared to 0, and tc_pulse and wrap_pulse SHALL be 0 in that cycle.
REQ-020 Out-of-range step: on any step with count > max (max lowered below count), count SHALL become max regardless of direction or WRAP.
REQ-021 Up step, count < max: count SHALL become count+1.
REQ-022 Up step, count == max: count SHALL hold if WRAP=0, or become 0 with wrap_pulse if WRAP=1.
REQ-023 Down step, count > 0: count SHALL become count-1.
REQ-024 Down step, count == 0: count SHALL hold if WRAP=0, or become max with wrap_pulse if WRAP=1.
REQ-025 tc_pulse SHALL be high for exactly the one cycle after a step that moves count onto its terminal value (max when up, 0 when down) from a different value.
REQ-026 Holding at a limit in saturate mode SHALL NOT re-pulse tc_pulse.
REQ-027 wrap_pulse SHALL be high for exactly the one cycle after a wrapping step.
REQ-028 tc_pulse and wrap_pulse SHALL NOT be high in the same cycle, and both SHALL be 0 in every cycle not preceded by a qualifying step.
REQ-029 max == 0 SHALL pin count at 0: every step holds; if WRAP=1 each step SHALL pulse wrap_pulse.
REQ-030 Arithmetic SHALL be unsigned modulo 2^WIDTH internally; no step SHALL carry or borrow beyond [0, max].
REQ-031 Step latency: count, tc_pulse and wrap_pulse SHALL update on the same edge that consumes the step.

Reset
REQ-032 While RESET=1 at an edge: count=0, psc=0, tc_pulse=0, wrap_pulse=0; load and count_en SHALL be ignored.
REQ-033 Reset asserted mid-prescale SHALL discard partial prescaler progress; the first step after reset SHALL need a full PRESCALE enabled cycles.

Verification
REQ-034 WIDTH=8, PRESCALE=1, WRAP=0, max=5, up, count_en=1 for 8 cycles -> count 1,2,3,4,5,5,5,5; tc_pulse only in the cycle count first reads 5; at_max high from then on.
REQ-035 WRAP=1, max=3, up, 6 steps from 0 -> count 1,2,3,0,1,2; tc_pulse with first 3; wrap_pulse with the 0.
REQ-036 PRESCALE=4, count_en toggled 1,1,0,1,1 from reset -> single step after the fourth enabled cycle; psc holds during the low cycle.
REQ-037 load=1 with load_val=200, max=100 while count_en=1 -> count=100 next cycle, psc=0, no pulses; load and RESET together -> count=0.
REQ-038 Down, WRAP=1, max=7, from 1 -> count 0 (tc_pulse) then 7 (wrap_pulse); then max lowered to 2 with count=7 and one step -> count=2.
REQ-039 RESET asserted for 1 cycle at count=42 with PRESCALE=3 partly advanced -> count=0; next step only after 3 enabled cycles.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down counter with runtime limit, saturate or wrap, and terminal/wrap pulses.
module prog_counter #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1,
  parameter int WRAP     = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             count_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc_pulse,
  output logic             wrap_pulse
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_TOP = PW'(PRESCALE - 1);
  logic [PW-1:0] psc;
  logic [WIDTH-1:0] step_val, load_sat;
  logic step, over, at_lim, wrap_now, tc_now;
  assign at_max  = count == max;
  assign at_zero = count == '0;
  // A count left above a lowered max snaps back to max before any limit logic applies.
  always_comb begin
    step     = count_en && psc == PSC_TOP;
    over     = count > max;
    at_lim   = up_dn ? at_max : at_zero;
    wrap_now = WRAP != 0 && !over && at_lim;
    step_val = over ? max
             : at_lim ? (wrap_now ? (up_dn ? '0 : max) : count)
             : up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
    tc_now   = !wrap_now && step_val != count && step_val == (up_dn ? max : '0);
    load_sat = load_val > max ? max : load_val;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count      <= '0;
      psc        <= '0;
      tc_pulse   <= 1'b0;
      wrap_pulse <= 1'b0;
    end else if (load) begin
      count      <= load_sat;
      psc        <= '0;
      tc_pulse   <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      if (count_en) psc <= step ? '0 : psc + PW'(1);
      if (step) count <= step_val;
      tc_pulse   <= step && tc_now;
      wrap_pulse <= step && wrap_now;
    end
  end
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: four prog_counter configurations on shared stimulus, checked against a behavioural model.
module tb_prog_counter;
  logic CLK = 1'b0, RESET = 1'b1, count_en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [7:0] load_val = '0, max = '0;
  logic [7:0] cnt [4];
  logic amax [4], azero [4], tc [4], wp [4];
  int mc [4], mp [4], mt [4], mw [4];
  int n_tests = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  // 0: P1 saturate, 1: P1 wrap, 2: P4 saturate, 3: P3 wrap
  for (genvar g = 0; g < 4; g++) begin : g_dut
    prog_counter #(.WIDTH(8), .PRESCALE(g == 2 ? 4 : g == 3 ? 3 : 1), .WRAP((g == 1 || g == 3) ? 1 : 0)) u (
      .CLK(CLK), .RESET(RESET), .count_en(count_en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .max(max), .count(cnt[g]), .at_max(amax[g]), .at_zero(azero[g]),
      .tc_pulse(tc[g]), .wrap_pulse(wp[g]));
  end

  function automatic int pre(int i);
    return i == 2 ? 4 : i == 3 ? 3 : 1;
  endfunction
  function automatic bit wrp(int i);
    return i == 1 || i == 3;
  endfunction

  task automatic model_edge();
    int c, m, nc;
    bit wr;
    for (int i = 0; i < 4; i++) begin
      if (RESET) begin
        mc[i] = 0; mp[i] = 0; mt[i] = 0; mw[i] = 0;
      end else if (load) begin
        mc[i] = load_val > max ? int'(max) : int'(load_val);
        mp[i] = 0; mt[i] = 0; mw[i] = 0;
      end else begin
        mt[i] = 0; mw[i] = 0;
        if (count_en) begin
          if (mp[i] == pre(i) - 1) begin
            mp[i] = 0;
            c = mc[i]; m = int'(max); wr = 0;
            if (c > m) nc = m;
            else if (up_dn) begin
              if (c < m) nc = c + 1;
              else if (wrp(i)) begin nc = 0; wr = 1; end
              else nc = c;
            end else begin
              if (c > 0) nc = c - 1;
              else if (wrp(i)) begin nc = m; wr = 1; end
              else nc = c;
            end
            mw[i] = wr;
            mt[i] = (!wr && nc != c && nc == (up_dn ? m : 0)) ? 1 : 0;
            mc[i] = nc;
          end else mp[i]++;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1; load = 0; count_en = 0;
    tick();
    RESET = 0;
  endtask

  task automatic test_reset();
    RESET = 1; count_en = 1; load = 1; load_val = 8'd9; max = 8'd50;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cnt[i] !== 8'd0 || tc[i] !== 1'b0 || wp[i] !== 1'b0 || azero[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset dut%0d: count=%0d tc=%b wp=%b at_zero=%b, want 0/0/0/1", i, cnt[i], tc[i], wp[i], azero[i]);
      end
    end
    RESET = 0; load = 0; count_en = 0;
  endtask

  task automatic test_saturate();
    int exp_c [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
    do_reset();
    max = 8'd5; up_dn = 1; count_en = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (cnt[0] !== 8'(exp_c[k]) || tc[0] !== (k == 4) || amax[0] !== (k >= 4)) begin
        n_fail++;
        $display("FAIL saturate step%0d: count=%0d tc=%b at_max=%b, want %0d/%b/%b", k, cnt[0], tc[0], amax[0], exp_c[k], k == 4, k >= 4);
      end
    end
    count_en = 0;
  endtask

  task automatic test_wrap();
    int exp_c [6] = '{1, 2, 3, 0, 1, 2};
    do_reset();
    max = 8'd3; up_dn = 1; count_en = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_tests++;
      if (cnt[1] !== 8'(exp_c[k]) || tc[1] !== (k == 2) || wp[1] !== (k == 3)) begin
        n_fail++;
        $display("FAIL wrap step%0d: count=%0d tc=%b wp=%b, want %0d/%b/%b", k, cnt[1], tc[1], wp[1], exp_c[k], k == 2, k == 3);
      end
    end
    count_en = 0;
  endtask

  task automatic test_prescale();
    bit en_pat [5] = '{1, 1, 0, 1, 1};
    do_reset();
    max = 8'd5; up_dn = 1;
    for (int k = 0; k < 5; k++) begin
      count_en = en_pat[k];
      tick();
      n_tests++;
      if (cnt[2] !== ((k == 4) ? 8'd1 : 8'd0)) begin
        n_fail++;
        $display("FAIL prescale cycle%0d: count=%0d, want %0d", k, cnt[2], k == 4 ? 1 : 0);
      end
    end
    count_en = 0;
  endtask

  task automatic test_load();
    do_reset();
    max = 8'd100; load_val = 8'd200; count_en = 1; up_dn = 1; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cnt[i] !== 8'd100 || tc[i] !== 1'b0 || wp[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL load_clamp dut%0d: count=%0d tc=%b wp=%b, want 100/0/0", i, cnt[i], tc[i], wp[i]);
      end
    end
    up_dn = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (cnt[2] !== ((k == 3) ? 8'd99 : 8'd100)) begin
        n_fail++;
        $display("FAIL load_psc_clear cycle%0d: count=%0d, want %0d", k, cnt[2], k == 3 ? 99 : 100);
      end
    end
    load = 1; RESET = 1;
    tick();
    load = 0; RESET = 0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (cnt[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL load_with_reset dut%0d: count=%0d, want 0", i, cnt[i]);
      end
    end
    count_en = 0;
  endtask

  task automatic test_down_wrap();
    do_reset();
    max = 8'd7; load_val = 8'd1; load = 1;
    tick();
    load = 0; up_dn = 0; count_en = 1;
    tick();
    n_tests++;
    if (cnt[1] !== 8'd0 || tc[1] !== 1'b1 || wp[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL down_to_zero: count=%0d tc=%b wp=%b, want 0/1/0", cnt[1], tc[1], wp[1]);
    end
    tick();
    n_tests++;
    if (cnt[1] !== 8'd7 || tc[1] !== 1'b0 || wp[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: count=%0d tc=%b wp=%b, want 7/0/1", cnt[1], tc[1], wp[1]);
    end
    count_en = 0; max = 8'd2;
    tick();
    count_en = 1;
    tick();
    count_en = 0;
    n_tests++;
    if (cnt[1] !== 8'd2 || wp[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL over_max_snap: count=%0d wp=%b, want 2/0", cnt[1], wp[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    max = 8'd200; load_val = 8'd42; load = 1;
    tick();
    load = 0; up_dn = 1; count_en = 1;
    tick(); tick();
    n_tests++;
    if (cnt[3] !== 8'd42) begin
      n_fail++;
      $display("FAIL reset_mid_pre: count=%0d, want 42", cnt[3]);
    end
    RESET = 1;
    tick();
    RESET = 0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (cnt[3] !== ((k == 3) ? 8'd1 : 8'd0)) begin
        n_fail++;
        $display("FAIL reset_mid cycle%0d: count=%0d, want %0d", k, cnt[3], k == 3 ? 1 : 0);
      end
      if (k < 3) tick();
    end
    count_en = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      RESET    = $urandom_range(0, 49) == 0;
      load     = $urandom_range(0, 15) == 0;
      load_val = 8'($urandom);
      count_en = $urandom_range(0, 3) != 0;
      up_dn    = 1'($urandom);
      if ($urandom_range(0, 7) == 0) max = $urandom_range(0, 9) == 0 ? 8'd255 : 8'($urandom_range(0, 12));
      tick();
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (cnt[i] !== 8'(mc[i]) || tc[i] !== 1'(mt[i]) || wp[i] !== 1'(mw[i]) ||
            amax[i] !== (mc[i] == int'(max)) || azero[i] !== (mc[i] == 0)) begin
          n_fail++;
          $display("FAIL random k%0d dut%0d: count=%0d tc=%b wp=%b at_max=%b at_zero=%b, want %0d/%0d/%0d/%b/%b",
                   k, i, cnt[i], tc[i], wp[i], amax[i], azero[i], mc[i], mt[i], mw[i], mc[i] == int'(max), mc[i] == 0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_prescale();
    test_load();
    test_down_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
